rx_frame_sequencer: RTL

- Receive-side frame controller for the UART core, instantiated in RxCore next to the shift register and byte analyser.
- Detects the start bit on the synchronised RX line and walks the frame through start, data, parity and stop phases on a 16x oversampling tick.
- Drives the one-hot State and the 4-bit BitWidthCnt consumed by the shift register and byte analyser. Issues the per-bit sample strobe and reports false-start and framing errors.

---
 rtl/rx_frame_sequencer_pkg.sv | 29 ++
 rtl/rx_start_detect.sv | 23 ++
 rtl/rx_frame_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rx_frame_sequencer_pkg.sv
// Shared definitions for the UART receive path: frame states, sampling points
// and the frame-error flag polarity used by the sequencer and the byte analyser.
package rx_frame_sequencer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_STARTBIT  = 5'b00010,
    ST_DATABITS  = 5'b00100,
    ST_PARITYBIT = 5'b01000,
    ST_STOPBIT   = 5'b10000
  } rx_state_e;

  localparam int NUM_DATA_BITS = 8;
  // Mid-bit sample point on the 16x oversample counter.
  localparam int ACQ_POINT     = 7;
  // Early exit in the last stop bit; the byte analyser writes its FIFO at 10.
  localparam int STOP_EXIT     = 11;

  localparam logic RIGHT = 1'b0;
  localparam logic WRONG = 1'b1;

  function automatic logic is_legal_state(input rx_state_e s);
    case (s)
      ST_IDLE, ST_STARTBIT, ST_DATABITS, ST_PARITYBIT, ST_STOPBIT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rx_start_detect.sv
// Start-bit qualification: accepts a low line seen on a tick while idle and
// rejects the start bit if the line is back high at the mid-bit sample.
module rx_start_detect
  import rx_frame_sequencer_pkg::*;
#(
  parameter int ACQSITION_POINT = ACQ_POINT
) (
  input  rx_state_e   state,
  input  logic [3:0]  bit_cnt,
  input  logic        baud_tick,
  input  logic        rx,
  output logic        start_ok,
  output logic        false_start
);

  // Level qualified rather than edge qualified so a held-low line (break)
  // restarts a frame on the first idle tick after the previous one ends.
  assign start_ok    = (state == ST_IDLE) && baud_tick && !rx;

  assign false_start = (state == ST_STARTBIT) && baud_tick && rx &&
                       (bit_cnt == 4'(ACQSITION_POINT));

endmodule

// File: rtl/rx_frame_sequencer.sv
// Receive frame controller: walks start/data/parity/stop phases on the 16x
// oversample tick and issues the per-bit sample strobe and error flags.
module rx_frame_sequencer
  import rx_frame_sequencer_pkg::*;
#(
  parameter int DATA_BITS       = NUM_DATA_BITS,
  parameter int ACQSITION_POINT = ACQ_POINT,
  parameter int STOP_EXIT_POINT = STOP_EXIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       baud_tick_i,
  input  logic       p_ParityEnable_i,
  input  logic       p_TwoStop_i,
  output logic [4:0] State_o,
  output logic [3:0] BitWidthCnt_o,
  output logic [2:0] BitIndex_o,
  output logic       Bit_Synch_o,
  output logic       p_FalseStart_o,
  output logic       p_FrameError_o
);

  rx_state_e  state_q;
  logic [3:0] cnt_q;
  logic [2:0] idx_q;
  logic       synch_q;
  logic       false_start_q;
  logic       frame_err_q;
  logic       par_en_q;
  logic       two_stop_q;
  logic       second_stop_q;

  logic start_ok;
  logic false_start;
  logic at_acq;
  logic at_exit;
  logic bit_end;
  logic last_bit;
  logic last_stop;

  rx_start_detect #(
    .ACQSITION_POINT (ACQSITION_POINT)
  ) u_start_detect (
    .state       (state_q),
    .bit_cnt     (cnt_q),
    .baud_tick   (baud_tick_i),
    .rx          (rx_i),
    .start_ok    (start_ok),
    .false_start (false_start)
  );

  assign at_acq    = (cnt_q == 4'(ACQSITION_POINT));
  assign at_exit   = (cnt_q == 4'(STOP_EXIT_POINT));
  assign bit_end   = (cnt_q == 4'd15);
  assign last_bit  = (idx_q == 3'(DATA_BITS - 1));
  assign last_stop = !two_stop_q || second_stop_q;

  // NOTE: every register here uses non-blocking assignment, so all branches
  // below decide on the pre-edge values of state_q, cnt_q and idx_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      synch_q       <= 1'b0;
      false_start_q <= 1'b0;
      frame_err_q   <= RIGHT;
      par_en_q      <= 1'b0;
      two_stop_q    <= 1'b0;
      second_stop_q <= 1'b0;
    end else begin
      // NOTE: pulses default low each clock and are set only on the
      // qualifying tick edge, which makes them exactly one clk wide.
      synch_q       <= 1'b0;
      false_start_q <= 1'b0;

      if (!is_legal_state(state_q)) begin
        state_q       <= ST_IDLE;
        cnt_q         <= '0;
        idx_q         <= '0;
        second_stop_q <= 1'b0;
      end else if (baud_tick_i) begin
        case (state_q)
          ST_IDLE: begin
            cnt_q <= '0;
            idx_q <= '0;
            if (start_ok) begin
              state_q       <= ST_STARTBIT;
              par_en_q      <= p_ParityEnable_i;
              two_stop_q    <= p_TwoStop_i;
              second_stop_q <= 1'b0;
              frame_err_q   <= RIGHT;
            end
          end

          ST_STARTBIT: begin
            if (false_start) begin
              state_q       <= ST_IDLE;
              cnt_q         <= '0;
              false_start_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
              if (bit_end) begin
                state_q <= ST_DATABITS;
                idx_q   <= '0;
              end
            end
          end

          ST_DATABITS: begin
            cnt_q   <= cnt_q + 4'd1;
            synch_q <= at_acq;
            if (bit_end) begin
              if (last_bit) begin
                state_q <= par_en_q ? ST_PARITYBIT : ST_STOPBIT;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end

          ST_PARITYBIT: begin
            cnt_q   <= cnt_q + 4'd1;
            synch_q <= at_acq;
            if (bit_end) state_q <= ST_STOPBIT;
          end

          ST_STOPBIT: begin
            synch_q <= at_acq;
            if (at_acq && !rx_i) frame_err_q <= WRONG;
            // The first of two stop bits runs to the wrap; the last one leaves
            // early so the next start edge is caught without slipping a tick.
            if (at_exit && last_stop) begin
              state_q       <= ST_IDLE;
              cnt_q         <= '0;
              second_stop_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
              if (bit_end) second_stop_q <= 1'b1;
            end
          end

          default: begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            second_stop_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign State_o        = state_q;
  assign BitWidthCnt_o  = cnt_q;
  assign BitIndex_o     = idx_q;
  assign Bit_Synch_o    = synch_q;
  assign p_FalseStart_o = false_start_q;
  assign p_FrameError_o = frame_err_q;

endmodule
